// File: rtl/siren_pkg.sv
// rtl/siren_pkg.sv - shared phase encoding, default parameters and sizing helper for the siren sequencer
package siren_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_RISE    = 3'd1,
    PH_HOLD_HI = 3'd2,
    PH_FALL    = 3'd3,
    PH_HOLD_LO = 3'd4
  } phase_t;

  localparam int DEF_DIV_W      = 8;
  localparam int DEF_P_MIN      = 4;
  localparam int DEF_P_MAX      = 8;
  localparam int DEF_STEP_TICKS = 16;
  localparam int DEF_YELP_TICKS = 4;
  localparam int DEF_HOLD_TICKS = 64;

  // Width needed for a timer that counts 0..max(a,b,c)-1.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/siren_sweep_sequencer_if.sv
// rtl/siren_sweep_sequencer_if.sv - control and observation bundle of the siren sweep sequencer
interface siren_sweep_sequencer_if
  import siren_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
);
  logic             en;
  logic             mode;
  logic             tone;
  logic [DIV_W-1:0] period;
  phase_t           phase;
  logic [1:0]       seg_sel;
  logic             busy;

  modport master (
    output en, mode,
    input  tone, period, phase, seg_sel, busy
  );

  modport slave (
    input  en, mode,
    output tone, period, phase, seg_sel, busy
  );
endinterface

// File: rtl/siren_tone_div.sv
// rtl/siren_tone_div.sv - half-period divider producing the square-wave tone
// The half-period in use is captured only at a wrap, so period updates never shorten a half-cycle.
module siren_tone_div #(
  parameter int               DIV_W = 8,
  parameter logic [DIV_W-1:0] RST_P = DIV_W'(8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tone,
  output logic             wrap
);

  logic [DIV_W-1:0] hc;
  logic [DIV_W-1:0] div_p;

  assign wrap = run && (hc == (div_p - DIV_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc    <= '0;
      tone  <= 1'b0;
      div_p <= RST_P;
    end else if (!run || clr) begin
      hc    <= '0;
      tone  <= 1'b0;
      div_p <= period;
    end else if (wrap) begin
      hc    <= '0;
      tone  <= ~tone;
      div_p <= period;
    end else begin
      hc    <= hc + DIV_W'(1);
    end
  end

endmodule

// File: rtl/siren_sweep_sequencer.sv
// rtl/siren_sweep_sequencer.sv - siren sweep FSM, step timer, period register and display rotation
// Sweeps the tone half-period between P_MAX and P_MIN in wail or yelp mode.
module siren_sweep_sequencer
  import siren_pkg::*;
#(
  parameter int DIV_W      = DEF_DIV_W,
  parameter int P_MIN      = DEF_P_MIN,
  parameter int P_MAX      = DEF_P_MAX,
  parameter int STEP_TICKS = DEF_STEP_TICKS,
  parameter int YELP_TICKS = DEF_YELP_TICKS,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic                    clk,
  input  logic                    rst,
  siren_sweep_sequencer_if.slave  bus
);

  localparam int ST_W = timer_width(STEP_TICKS, YELP_TICKS, HOLD_TICKS);

  localparam logic [2:0] S_IDLE    = PH_IDLE;
  localparam logic [2:0] S_RISE    = PH_RISE;
  localparam logic [2:0] S_HOLD_HI = PH_HOLD_HI;
  localparam logic [2:0] S_FALL    = PH_FALL;
  localparam logic [2:0] S_HOLD_LO = PH_HOLD_LO;

  localparam logic [ST_W-1:0]  ST_STEP_LAST = ST_W'(STEP_TICKS - 1);
  localparam logic [ST_W-1:0]  ST_YELP_LAST = ST_W'(YELP_TICKS - 1);
  localparam logic [ST_W-1:0]  ST_HOLD_LAST = ST_W'(HOLD_TICKS - 1);
  localparam logic [DIV_W-1:0] PMIN_V       = DIV_W'(P_MIN);
  localparam logic [DIV_W-1:0] PMAX_V       = DIV_W'(P_MAX);

  logic [2:0]       state;
  logic [DIV_W-1:0] period_q;
  logic [ST_W-1:0]  st;
  logic             mode_l;
  logic             draining;
  logic [1:0]       seg_q;

  logic             tone;
  logic             wrap;
  logic             busy;
  logic             stop_req;
  logic             go_idle;
  logic             step_due;
  logic             hold_due;
  logic [DIV_W-1:0] period_dn;
  logic [DIV_W-1:0] period_up;

  assign busy      = (state != S_IDLE);
  // Once a stop is seen the drain is committed; a re-asserted en cannot cancel it.
  assign stop_req  = !bus.en || draining;
  assign go_idle   = busy && stop_req && (!tone || wrap);
  assign step_due  = (st == (mode_l ? ST_YELP_LAST : ST_STEP_LAST));
  assign hold_due  = (st == ST_HOLD_LAST);
  assign period_dn = period_q - DIV_W'(1);
  assign period_up = period_q + DIV_W'(1);

  siren_tone_div #(
    .DIV_W (DIV_W),
    .RST_P (PMAX_V)
  ) u_tone_div (
    .clk    (clk),
    .rst    (rst),
    .run    (busy),
    .clr    (go_idle),
    .period (period_q),
    .tone   (tone),
    .wrap   (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      period_q <= PMAX_V;
      st       <= '0;
      mode_l   <= 1'b0;
      draining <= 1'b0;
      seg_q    <= 2'd0;
    end else if (!busy) begin
      draining <= 1'b0;
      st       <= '0;
      period_q <= PMAX_V;
      if (bus.en) begin
        state  <= S_RISE;
        mode_l <= bus.mode;
      end
    end else if (go_idle) begin
      state    <= S_IDLE;
      period_q <= PMAX_V;
      st       <= '0;
      draining <= 1'b0;
    end else begin
      if (stop_req) draining <= 1'b1;
      st <= st + ST_W'(1);
      case (state)
        S_RISE: begin
          if (step_due) begin
            st <= '0;
            if (period_dn <= PMIN_V) begin
              period_q <= PMIN_V;
              state    <= mode_l ? S_FALL : S_HOLD_HI;
            end else begin
              period_q <= period_dn;
            end
          end
        end
        S_FALL: begin
          if (step_due) begin
            st <= '0;
            if (period_up >= PMAX_V) begin
              period_q <= PMAX_V;
              if (mode_l) begin
                state  <= S_RISE;
                mode_l <= bus.mode;
                seg_q  <= seg_q + 2'd1;
              end else begin
                state  <= S_HOLD_LO;
              end
            end else begin
              period_q <= period_up;
            end
          end
        end
        S_HOLD_HI: begin
          if (hold_due) begin
            st    <= '0;
            state <= S_FALL;
          end
        end
        S_HOLD_LO: begin
          if (hold_due) begin
            st     <= '0;
            state  <= S_RISE;
            mode_l <= bus.mode;
            seg_q  <= seg_q + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tone    = tone;
  assign bus.period  = period_q;
  assign bus.phase   = phase_t'(state);
  assign bus.seg_sel = seg_q;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_siren_sweep_sequencer.sv
// tb/tb_siren_sweep_sequencer.sv - scenario tasks and random run against a time-based siren model
module tb_siren_sweep_sequencer;
  import siren_pkg::*;

  localparam int P_MIN = 4;
  localparam int P_MAX = 8;
  localparam int STEP  = 16;
  localparam int YELP  = 4;
  localparam int HOLD  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  siren_sweep_sequencer_if #(.DIV_W(8)) bus ();

  siren_sweep_sequencer #(
    .DIV_W(8), .P_MIN(P_MIN), .P_MAX(P_MAX),
    .STEP_TICKS(STEP), .YELP_TICKS(YELP), .HOLD_TICKS(HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: period follows from time spent in the current phase; tone from time since last toggle.
  int m_phase = 0, m_t = 0, m_mode = 0, m_seg = 0;
  int m_tone = 0, m_since = 0, m_half = P_MAX, m_drain = 0;
  int m_cur_p, m_wrap, m_stop;

  function automatic int phase_len(input int ph, input int md);
    if (ph == 1 || ph == 3) return (P_MAX - P_MIN) * (md != 0 ? YELP : STEP);
    return HOLD;
  endfunction

  function automatic int m_period();
    int t_step;
    t_step = (m_mode != 0) ? YELP : STEP;
    case (m_phase)
      1:       return P_MAX - m_t / t_step;
      2:       return P_MIN;
      3:       return P_MIN + m_t / t_step;
      default: return P_MAX;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_t = 0; m_mode = 0; m_seg = 0;
      m_tone = 0; m_since = 0; m_half = P_MAX; m_drain = 0;
    end else if (m_phase == 0) begin
      if (bus.en) begin
        m_phase = 1; m_t = 0; m_mode = int'(bus.mode);
        m_tone = 0; m_since = 0; m_half = P_MAX;
      end
    end else begin
      m_cur_p = m_period();
      m_wrap  = (m_since == m_half - 1) ? 1 : 0;
      m_stop  = (!bus.en || m_drain != 0) ? 1 : 0;
      if (m_stop != 0 && (m_tone == 0 || m_wrap != 0)) begin
        m_phase = 0; m_tone = 0; m_drain = 0; m_t = 0;
      end else begin
        if (m_stop != 0) m_drain = 1;
        if (m_wrap != 0) begin
          m_tone = 1 - m_tone; m_since = 0; m_half = m_cur_p;
        end else begin
          m_since++;
        end
        m_t++;
        if (m_t == phase_len(m_phase, m_mode)) begin
          m_t = 0;
          case (m_phase)
            1: m_phase = (m_mode != 0) ? 3 : 2;
            2: m_phase = 3;
            3: m_phase = (m_mode != 0) ? 1 : 4;
            default: m_phase = 1;
          endcase
          if (m_phase == 1) begin
            m_mode = int'(bus.mode);
            m_seg  = (m_seg + 1) % 4;
          end
        end
      end
    end
  end

  function automatic logic [14:0] dut_vec();
    return {bus.phase, bus.period, bus.tone, bus.seg_sel, bus.busy};
  endfunction

  function automatic logic [14:0] model_vec();
    return {3'(m_phase), 8'(m_period()), 1'(m_tone), 2'(m_seg), (m_phase != 0)};
  endfunction

  task automatic test_reset();
    bus.en = 1'b0; bus.mode = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (dut_vec() !== 15'({3'd0, 8'd8, 1'b0, 2'd0, 1'b0})) begin
      fails++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 15'({3'd0, 8'd8, 1'b0, 2'd0, 1'b0}));
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic stop_siren(input string name);
    bus.en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.phase == PH_IDLE) break;
    end
    tests++;
    if (bus.phase !== PH_IDLE || dut_vec() !== model_vec()) begin
      fails++; $display("FAIL %s_stop: got %h expected %h", name, dut_vec(), model_vec());
    end
  endtask

  task automatic test_wail();
    bus.mode = 1'b0; bus.en = 1'b1;
    for (int k = 0; k <= 1030; k++) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL wail_model k=%0d: got %h expected %h", k, dut_vec(), model_vec());
      end
      if (k == 0) begin
        tests++;
        if (bus.phase !== PH_RISE || bus.tone !== 1'b0) begin
          fails++; $display("FAIL wail_enter: phase %0d tone %b expected 1 0", bus.phase, bus.tone);
        end
      end
      if (k == 7 || k == 8) begin
        tests++;
        if (bus.tone !== (k == 8)) begin
          fails++; $display("FAIL wail_first_tone k=%0d: got %b expected %b", k, bus.tone, (k == 8));
        end
      end
      if (k == 15 || k == 16 || k == 63) begin
        tests++;
        if (bus.period !== ((k == 15) ? 8'd8 : (k == 16) ? 8'd7 : 8'd5)) begin
          fails++; $display("FAIL wail_step k=%0d: got %0d", k, bus.period);
        end
      end
      if (k == 64 || k == 128 || k == 192) begin
        tests++;
        if (bus.phase !== ((k == 64) ? PH_HOLD_HI : (k == 128) ? PH_FALL : PH_HOLD_LO) ||
            bus.period !== ((k == 128) ? 8'd4 : (k == 64) ? 8'd4 : 8'd8)) begin
          fails++; $display("FAIL wail_phase k=%0d: phase %0d period %0d", k, bus.phase, bus.period);
        end
      end
      if (k == 256 || k == 1023 || k == 1024) begin
        tests++;
        if (bus.phase !== ((k == 1023) ? PH_HOLD_LO : PH_RISE) ||
            bus.seg_sel !== ((k == 256) ? 2'd1 : (k == 1023) ? 2'd3 : 2'd0)) begin
          fails++; $display("FAIL wail_seg k=%0d: phase %0d seg %0d", k, bus.phase, bus.seg_sel);
        end
      end
    end
    stop_siren("wail");
  endtask

  task automatic test_yelp();
    bus.mode = 1'b1; bus.en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== model_vec() || (bus.phase !== PH_RISE && bus.phase !== PH_FALL)) begin
        fails++; $display("FAIL yelp_model k=%0d: got %h expected %h", k, dut_vec(), model_vec());
      end
      if (k == 4 || k == 16 || k == 32) begin
        tests++;
        if (bus.period !== ((k == 4) ? 8'd7 : (k == 16) ? 8'd4 : 8'd8) ||
            bus.phase !== ((k == 16) ? PH_FALL : PH_RISE)) begin
          fails++; $display("FAIL yelp_step k=%0d: phase %0d period %0d", k, bus.phase, bus.period);
        end
      end
    end
    stop_siren("yelp");
  endtask

  task automatic test_mode_flip();
    bus.mode = 1'b0; bus.en = 1'b1;
    for (int k = 0; k <= 300; k++) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL flip_model k=%0d: got %h expected %h", k, dut_vec(), model_vec());
      end
      if (k == 32 || k == 64 || k == 256 || k == 260 || k == 272) begin
        tests++;
        if (bus.phase !== ((k == 64) ? PH_HOLD_HI : (k == 272) ? PH_FALL : PH_RISE) ||
            bus.period !== ((k == 32) ? 8'd6 : (k == 256) ? 8'd8 : (k == 260) ? 8'd7 : 8'd4)) begin
          fails++; $display("FAIL flip_timing k=%0d: phase %0d period %0d", k, bus.phase, bus.period);
        end
      end
      if (k == 20) bus.mode = 1'b1;
    end
    stop_siren("flip");
  endtask

  task automatic test_drain();
    bit found = 0;
    bit seen_idle = 0;
    bus.mode = 1'b0; bus.en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.period == 8'd6 && bus.tone == 1'b1 && bus.phase == PH_RISE) begin
        found = 1; break;
      end
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL drain_setup: period %0d tone %b never reached 6 1", bus.period, bus.tone);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL drain_model i=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      tests++;
      if (bus.tone === 1'b0) begin
        if ({bus.phase, bus.period, bus.busy} !== 12'({3'd0, 8'd8, 1'b0})) begin
          fails++; $display("FAIL drain_idle: phase %0d period %0d busy %b expected 0 8 0", bus.phase, bus.period, bus.busy);
        end
        seen_idle = 1;
        bus.en = 1'b1;
        break;
      end else if (bus.busy !== 1'b1) begin
        fails++; $display("FAIL drain_busy: busy %b expected 1", bus.busy);
      end
      bus.en = 1'b1;
    end
    tests++;
    if (!seen_idle) begin
      fails++; $display("FAIL drain_timeout: tone %b phase %0d", bus.tone, bus.phase);
    end
    @(negedge clk);
    tests++;
    if (bus.phase !== PH_RISE || bus.tone !== 1'b0 || dut_vec() !== model_vec()) begin
      fails++; $display("FAIL drain_restart: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.tone == 1'b1 && bus.phase == PH_RISE) begin
        found = 1; break;
      end
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (!found || dut_vec() !== 15'({3'd0, 8'd8, 1'b0, 2'd0, 1'b0})) begin
      fails++; $display("FAIL reset_mid: got %h expected %h (tone seen %b)", dut_vec(), 15'({3'd0, 8'd8, 1'b0, 2'd0, 1'b0}), found);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL random k=%0d: got %h expected %h", k, dut_vec(), model_vec());
      end
      if ($urandom_range(0, 99) < 2) bus.en = ~bus.en;
      if ($urandom_range(0, 99) < 4) bus.mode = ~bus.mode;
    end
  endtask

  initial begin
    test_reset();
    test_wail();
    test_yelp();
    test_mode_flip();
    test_drain();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
